// File: rtl/uart_tx_serializer_if.sv
// Byte handshake, baud enable and serial-line status between a UART TX
// serializer and its user.
interface uart_tx_serializer_if;
  logic       baud_tick;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_serial;
  logic       tx_active;
  logic       tx_done;

  modport master (
    output baud_tick, tx_data, tx_valid,
    input  tx_ready, tx_serial, tx_active, tx_done
  );

  modport slave (
    input  baud_tick, tx_data, tx_valid,
    output tx_ready, tx_serial, tx_active, tx_done
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART frame serializer: start, DATA_BITS LSB first, optional parity, 1-2 stop bits.
// Start bit waits for the first baud tick after acceptance; tx_ready is high only in IDLE.
module uart_tx_serializer #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  uart_tx_serializer_if.slave  tx
);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_serializer: DATA_BITS must be 5..8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [2:0]           idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic                 par_q, par_d;
  logic                 serial_q, serial_d;
  logic                 done_q, done_d;
  logic                 unused_data_bits;

  assign unused_data_bits = ^tx.tx_data;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      par_q    <= 1'b0;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      par_q    <= par_d;
      serial_q <= serial_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    idx_d    = idx_q;
    stop_d   = stop_q;
    par_d    = par_q;
    serial_d = serial_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        serial_d = 1'b1;
        if (tx.tx_valid) begin
          data_d  = tx.tx_data[DATA_BITS-1:0];
          // Odd parity is the inverted XOR so the frame carries an odd count of ones.
          par_d   = (PARITY == 1) ? ~(^tx.tx_data[DATA_BITS-1:0])
                                  :  (^tx.tx_data[DATA_BITS-1:0]);
          state_d = S_SYNC;
        end
      end
      S_SYNC: begin
        if (tx.baud_tick) begin
          state_d  = S_START;
          serial_d = 1'b0;
        end
      end
      S_START: begin
        if (tx.baud_tick) begin
          state_d  = S_DATA;
          idx_d    = '0;
          serial_d = data_q[0];
        end
      end
      S_DATA: begin
        if (tx.baud_tick) begin
          if (idx_q == LAST_IDX) begin
            stop_d = 1'b0;
            if (PARITY != 0) begin
              state_d  = S_PARITY;
              serial_d = par_q;
            end else begin
              state_d  = S_STOP;
              serial_d = 1'b1;
            end
          end else begin
            idx_d    = idx_q + 3'd1;
            serial_d = data_q[idx_q + 3'd1];
          end
        end
      end
      S_PARITY: begin
        if (tx.baud_tick) begin
          state_d  = S_STOP;
          serial_d = 1'b1;
          stop_d   = 1'b0;
        end
      end
      S_STOP: begin
        if (tx.baud_tick) begin
          if (stop_q == LAST_STOP) begin
            state_d  = S_IDLE;
            done_d   = 1'b1;
            serial_d = 1'b1;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        serial_d = 1'b1;
      end
    endcase
  end

  assign tx.tx_serial = serial_q;
  assign tx.tx_done   = done_q;
  assign tx.tx_ready  = (state_q == S_IDLE);
  assign tx.tx_active = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: 8N1, 7E2 and 7O2 instances sharing one baud tick.
module tb_uart_tx_serializer;

  logic       clk;
  logic       rst_n;
  logic       tick;
  int         tick_p;
  int         tcnt;
  int         sel;
  logic       valid_v [3];
  logic [7:0] data_v  [3];
  logic       ser_m, rdy_m, act_m, done_m;
  int         done_cnt;
  int         n_tests;
  int         n_fail;

  uart_tx_serializer_if if0 ();
  uart_tx_serializer_if if1 ();
  uart_tx_serializer_if if2 ();

  assign if0.baud_tick = tick;
  assign if1.baud_tick = tick;
  assign if2.baud_tick = tick;
  assign if0.tx_valid  = valid_v[0];
  assign if1.tx_valid  = valid_v[1];
  assign if2.tx_valid  = valid_v[2];
  assign if0.tx_data   = data_v[0];
  assign if1.tx_data   = data_v[1];
  assign if2.tx_data   = data_v[2];

  uart_tx_serializer #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .i_Clk(clk), .i_Rst_L(rst_n), .tx(if0));
  uart_tx_serializer #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7e2 (
    .i_Clk(clk), .i_Rst_L(rst_n), .tx(if1));
  uart_tx_serializer #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
    .i_Clk(clk), .i_Rst_L(rst_n), .tx(if2));

  always_comb begin
    case (sel)
      1:       begin ser_m = if1.tx_serial; rdy_m = if1.tx_ready; act_m = if1.tx_active; done_m = if1.tx_done; end
      2:       begin ser_m = if2.tx_serial; rdy_m = if2.tx_ready; act_m = if2.tx_active; done_m = if2.tx_done; end
      default: begin ser_m = if0.tx_serial; rdy_m = if0.tx_ready; act_m = if0.tx_active; done_m = if0.tx_done; end
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tick changes on the falling edge, so the DUT samples it cleanly on the next rising edge.
  initial begin
    tick = 1'b0;
    tcnt = 0;
    forever begin
      @(negedge clk);
      if (tick_p <= 0) tick = 1'b0;
      else if (tick_p == 1) tick = 1'b1;
      else begin
        tick = (tcnt == tick_p - 1);
        tcnt = (tcnt + 1) % tick_p;
      end
    end
  end

  always @(posedge clk) if (done_m === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic accept(input int s, input logic [7:0] d, input bit hold);
    int w;
    w = 0;
    sel = s;
    @(negedge clk);
    while (rdy_m !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    check_val("ready before accept", rdy_m, 1);
    valid_v[s] = 1'b1;
    data_v[s]  = d;
    @(negedge clk);
    check_val("ready after accept", rdy_m, 0);
    check_val("active after accept", act_m, 1);
    check_val("line high after accept", ser_m, 1);
    if (!hold) valid_v[s] = 1'b0;
    data_v[s] = ~d;
  endtask

  // exp holds the frame bits in line order as '0'/'1' characters; p is clocks per bit.
  task automatic check_frame(input string tag, input string exp, input int p);
    int w;
    int hi_rdy;
    int d0;
    w = 0;
    hi_rdy = 0;
    d0 = done_cnt;
    while (ser_m !== 1'b0 && w < 200) begin @(negedge clk); w++; end
    check_val({tag, " start latency"}, (w >= 1 && w <= p), 1);
    if (ser_m !== 1'b0) return;
    for (int j = 0; j < exp.len(); j++) begin
      for (int k = 0; k < p; k++) begin
        if (k == 0 || k == p - 1)
          check_val($sformatf("%s bit%0d clk%0d", tag, j, k), ser_m, (exp[j] == "1"));
        if (rdy_m !== 1'b0) hi_rdy++;
        @(negedge clk);
      end
    end
    check_val({tag, " done at end"}, done_m, 1);
    check_val({tag, " ready at end"}, rdy_m, 1);
    check_val({tag, " ready low in frame"}, hi_rdy, 0);
    @(negedge clk);
    check_val({tag, " done pulses"}, done_cnt - d0, 1);
  endtask

  initial begin
    int w;
    n_tests  = 0;
    n_fail   = 0;
    done_cnt = 0;
    sel      = 0;
    tick_p   = 8;
    rst_n    = 1'b0;
    for (int i = 0; i < 3; i++) begin valid_v[i] = 1'b0; data_v[i] = 8'h00; end
    repeat (3) @(negedge clk);
    check_val("reset line", if0.tx_serial, 1);
    check_val("reset ready", if0.tx_ready, 1);
    check_val("reset active", if0.tx_active, 0);
    check_val("reset done", if0.tx_done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    accept(0, 8'hA5, 0);
    check_frame("8n1 a5", "0101001011", 8);

    accept(1, 8'h07, 0);
    check_frame("7e2 07", "01110000111", 8);

    accept(2, 8'h07, 0);
    check_frame("7o2 07", "01110000011", 8);

    // Valid held: 0x00 then 0xFF queued in tx_data while the first frame runs.
    accept(0, 8'h00, 1);
    check_frame("held 00", "0000000001", 8);
    check_val("second accept ready", rdy_m, 0);
    check_val("second accept active", act_m, 1);
    check_val("gap line high", ser_m, 1);
    valid_v[0] = 1'b0;
    data_v[0]  = 8'h12;
    check_frame("held ff", "0111111111", 8);

    // Reset in the middle of data bit 3 of 0x55.
    accept(0, 8'h55, 0);
    w = 0;
    while (ser_m !== 1'b0 && w < 200) begin @(negedge clk); w++; end
    repeat (4 * 8 + 2) @(negedge clk);
    check_val("55 data bit3", ser_m, 0);
    rst_n = 1'b0;
    #1;
    check_val("mid reset line", if0.tx_serial, 1);
    check_val("mid reset ready", if0.tx_ready, 1);
    check_val("mid reset active", if0.tx_active, 0);
    check_val("mid reset done", if0.tx_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post reset ready", if0.tx_ready, 1);
    accept(0, 8'h3C, 0);
    check_frame("after rst 3c", "0001111001", 8);

    // Tick tied high: the tick on the acceptance edge must not launch the start bit.
    tick_p = 1;
    accept(0, 8'h81, 0);
    check_frame("tick hi 81", "0100000011", 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
